rs_branch: RTL

RS_BRANCH -- requirements
Module: rs_branch

---
 rtl/sys_defs.sv | 82 ++++++++
 rtl/rs_br_psel.sv | 26 ++
 rtl/rs_branch.sv | 109 ++++++++++
 3 files changed

// File: rtl/sys_defs.sv
// sys_defs: shared widths and bundles for the branch
// reservation station.
package sys_defs;

  localparam int XLEN = 32;
  localparam int PRF_LEN = 6;
  localparam int ROB_LEN = 5;
  localparam int RS_BR_SIZE_DEFAULT = 4;

  typedef struct packed {
    logic [XLEN-1:0]    PC;
    logic [XLEN-1:0]    offset;
    logic               cond_branch;
    logic [2:0]         func;
    logic               opa_ready;
    logic               opb_ready;
    logic [XLEN-1:0]    opa_value;
    logic [XLEN-1:0]    opb_value;
    logic [PRF_LEN-1:0] opa_preg_idx;
    logic [PRF_LEN-1:0] opb_preg_idx;
    logic [PRF_LEN-1:0] dest_preg_idx;
    logic [ROB_LEN-1:0] rob_idx;
    logic               br_pred_direction;
    logic [XLEN-1:0]    br_pred_target_PC;
    logic               local_pred_direction;
    logic               global_pred_direction;
  } RS_BRANCH_DISPATCH;

  typedef struct packed {
    logic [XLEN-1:0]    PC;
    logic [XLEN-1:0]    offset;
    logic               cond_branch;
    logic [2:0]         func;
    logic [XLEN-1:0]    opa_value;
    logic [XLEN-1:0]    opb_value;
    logic [PRF_LEN-1:0] dest_preg_idx;
    logic [ROB_LEN-1:0] rob_idx;
    logic               br_pred_direction;
    logic [XLEN-1:0]    br_pred_target_PC;
    logic               local_pred_direction;
    logic               global_pred_direction;
  } RS_BRANCH_PACKET;

  function automatic RS_BRANCH_DISPATCH rs_br_wakeup(
    input RS_BRANCH_DISPATCH  p,
    input logic               v,
    input logic [PRF_LEN-1:0] tag,
    input logic [XLEN-1:0]    val
  );
    RS_BRANCH_DISPATCH q;
    q = p;
    if (v && !p.opa_ready && p.opa_preg_idx == tag) begin
      q.opa_ready = 1'b1;
      q.opa_value = val;
    end
    if (v && !p.opb_ready && p.opb_preg_idx == tag) begin
      q.opb_ready = 1'b1;
      q.opb_value = val;
    end
    return q;
  endfunction

  function automatic RS_BRANCH_PACKET rs_br_to_packet(
    input RS_BRANCH_DISPATCH p
  );
    RS_BRANCH_PACKET q;
    q.PC = p.PC;
    q.offset = p.offset;
    q.cond_branch = p.cond_branch;
    q.func = p.func;
    q.opa_value = p.opa_value;
    q.opb_value = p.opb_value;
    q.dest_preg_idx = p.dest_preg_idx;
    q.rob_idx = p.rob_idx;
    q.br_pred_direction = p.br_pred_direction;
    q.br_pred_target_PC = p.br_pred_target_PC;
    q.local_pred_direction = p.local_pred_direction;
    q.global_pred_direction = p.global_pred_direction;
    return q;
  endfunction

endpackage

// File: rtl/rs_br_psel.sv
// rs_br_psel: lowest-index priority selector returning
// an any-flag and the binary index of the winner.
import sys_defs::*;

module rs_br_psel #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  output logic         any,
  output logic [W-1:0] idx
);

  // Scan high to low so the lowest set bit is written last.
  always_comb begin
    any = 1'b0;
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        any = 1'b1;
        idx = W'(i);
      end
    end
  end

endmodule

// File: rtl/rs_branch.sv
// rs_branch: branch reservation station with CDB wakeup
// and lowest-index select into a registered issue slot.
import sys_defs::*;

module rs_branch #(
  parameter int RS_BR_SIZE = RS_BR_SIZE_DEFAULT
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               dispatch_valid,
  input  RS_BRANCH_DISPATCH  dispatch_packet,
  input  logic               cdb_valid,
  input  logic [PRF_LEN-1:0] cdb_preg_idx,
  input  logic [XLEN-1:0]    cdb_value,
  input  logic               branch_unit_free,
  input  logic               flush,
  output logic               rs_full,
  output logic               branch_enable,
  output RS_BRANCH_PACKET    rs_branch_packet
);

  localparam int IW = $clog2(RS_BR_SIZE);

  RS_BRANCH_DISPATCH ent     [RS_BR_SIZE];
  RS_BRANCH_DISPATCH ent_nxt [RS_BR_SIZE];

  logic [RS_BR_SIZE-1:0] valid;
  logic [RS_BR_SIZE-1:0] valid_nxt;
  logic [RS_BR_SIZE-1:0] free;
  logic [RS_BR_SIZE-1:0] ready;
  logic                  free_any;
  logic                  ready_any;
  logic [IW-1:0]         free_idx;
  logic [IW-1:0]         ready_idx;
  logic                  disp_fire;
  logic                  issue_fire;

  // Selection sees only pre-edge state, so a fresh entry
  // waits a cycle and a freed slot is not reused at once.
  always_comb begin
    free  = '0;
    ready = '0;
    for (int i = 0; i < RS_BR_SIZE; i++) begin
      free[i]  = ~valid[i];
      ready[i] = valid[i] & ent[i].opa_ready
                 & ent[i].opb_ready;
    end
  end

  rs_br_psel #(.N(RS_BR_SIZE), .W(IW)) u_free_sel (
    .req (free),
    .any (free_any),
    .idx (free_idx)
  );

  rs_br_psel #(.N(RS_BR_SIZE), .W(IW)) u_issue_sel (
    .req (ready),
    .any (ready_any),
    .idx (ready_idx)
  );

  assign disp_fire  = dispatch_valid & ~rs_full & free_any;
  assign issue_fire = branch_unit_free & ready_any;

  always_comb begin
    valid_nxt = valid;
    for (int i = 0; i < RS_BR_SIZE; i++) begin
      ent_nxt[i] = rs_br_wakeup(ent[i], cdb_valid,
                                cdb_preg_idx, cdb_value);
    end
    if (issue_fire) begin
      valid_nxt[ready_idx] = 1'b0;
    end
    if (disp_fire) begin
      valid_nxt[free_idx] = 1'b1;
      ent_nxt[free_idx] = rs_br_wakeup(dispatch_packet,
                                       cdb_valid,
                                       cdb_preg_idx,
                                       cdb_value);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      valid            <= '0;
      rs_full          <= 1'b0;
      branch_enable    <= 1'b0;
      rs_branch_packet <= '0;
    end else if (flush) begin
      valid         <= '0;
      rs_full       <= 1'b0;
      branch_enable <= 1'b0;
    end else begin
      valid         <= valid_nxt;
      rs_full       <= &valid_nxt;
      branch_enable <= issue_fire;
      if (issue_fire) begin
        rs_branch_packet <= rs_br_to_packet(ent[ready_idx]);
      end
    end
  end

  always_ff @(posedge clock) begin
    for (int i = 0; i < RS_BR_SIZE; i++) begin
      ent[i] <= ent_nxt[i];
    end
  end

endmodule
